regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised general-purpose register file with a per-register pending-write scoreboard, for the pipelined core.
- Two combinational read ports and one synchronous write port.
- Optional same-cycle write-to-read bypass.
- Register 0 is optionally hardwired to zero.
- The scoreboard tracks destinations of issued-but-not-written-back instructions, so the issue stage can stall on RAW hazards.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never pending
BYPASS, 1, 1 = same-cycle write data forwarded to read ports and clears busy

Ports:
iClk  in  1  clock, rising edge
nRst  in  1  asynchronous active-low reset
iAddrA  in  ADDR_W  read port A address
iAddrB  in  ADDR_W  read port B address
oRegA  out  DATA_W  read port A data
oRegB  out  DATA_W  read port B data
oBusyA  out  1  register at iAddrA has a pending write
oBusyB  out  1  register at iAddrB has a pending write
iWrite  in  1  writeback enable
iAddrC  in  ADDR_W  writeback address
iRegC  in  DATA_W  writeback data
iIssue  in  1  mark iIssueAddr pending
iIssueAddr  in  ADDR_W  destination of issued instruction
iFlush  in  1  clear all pending bits (pipeline flush)
oPendCnt  out  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset (nRst low, asynchronous): all registers and pending bits cleared; oPendCnt=0. Consequently oRegA/B=0 and oBusyA/B=0.
- Write: on the rising edge with iWrite=1, reg[iAddrC] <= iRegC. With ZERO_REG=1 and iAddrC=0, the write is ignored.
- Read: combinational.
  - ZERO_REG=1 and address 0 -> 0.
  - Else if BYPASS=1, iWrite=1 and iAddrC equals the read address -> iRegC.
  - Else reg[addr].
- Pending bits, next-state priority per address k, highest first:
  1. iFlush=1 -> 0 (a same-cycle issue is dropped).
  2. iIssue=1 and iIssueAddr=k -> 1 (set beats a same-cycle write to k; the newer producer owns k).
  3. iWrite=1 and iAddrC=k -> 0.
  4. Otherwise hold.
  - With ZERO_REG=1, the pending bit of address 0 is constant 0.
- Write data always updates the register regardless of flush or pending state.
- Busy outputs:
  - oBusyX = pend[addrX], except when BYPASS=1, iWrite=1, iAddrC=addrX and the entry is not being re-issued this cycle; then 0.
  - Address 0 with ZERO_REG=1 is always 0.
- oPendCnt:
  - Registered; equals the popcount of the pending bits after each edge.
  - Maintained incrementally: +1 when an issue sets a clear bit; −1 when a write clears a set bit; net 0 when both occur on different addresses.
  - Flush -> 0.
  - Never wraps: the maximum is 2**ADDR_W − ZERO_REG, which fits in ADDR_W+1 bits.
- Latency: write visible on the read port the next cycle (same cycle with BYPASS=1). Issue visible on busy the next cycle.
- Reset mid-operation: all state is lost immediately; no write or issue in flight completes.

Decomposition:
- Package regfile_pkg: default DATA_W/ADDR_W constants, a function computing the pending-count width, and the address type.
- One natural sub-module, reg_en: DATA_W-wide enabled register with async active-low clear. Instantiate it with a generate loop over 2**ADDR_W entries; entry 0 is omitted when ZERO_REG=1.
- Implement the read muxes as indexed arrays, not unrolled comparisons.

Test Plan:
- Reset, then write r5=0xDEADBEEF; the next cycle read A=5, B=0 -> oRegA=0xDEADBEEF, oRegB=0. Write r0=0x1234 -> r0 still reads 0.
- BYPASS=1: iWrite r7=0xA5A5A5A5 with iAddrA=7 in the same cycle -> oRegA=0xA5A5A5A5 combinationally. Repeat with BYPASS=0 -> old value 0.
- Issue r3, r4 on successive cycles -> oPendCnt 1 then 2, oBusyA(3)=1. Write r3 -> oBusyA(3)=0 in the same cycle, oPendCnt=1 after the edge.
- Issue r9 and write r9 in the same cycle (r9 pending) -> r9 still pending, data updated, oPendCnt unchanged.
- Pend r1..r6, then iFlush together with iIssue r8 -> all busy=0, oPendCnt=0, r8 not pending.
- Issue all 31 non-zero registers -> oPendCnt=31. Issue r0 -> no change. Assert nRst low mid-sequence -> oPendCnt=0 and all registers read 0 without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register file / scoreboard.
//   DEF_DATA_W / DEF_ADDR_W : default register width and address width
//   pend_cnt_w()            : width of the pending-register counter
//   addr_t                  : register address at the default width
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef logic [DEF_ADDR_W-1:0] addr_t;

    // One extra bit over the address width. This holds every count up to
    // 2**addr_w, so the pending counter can never wrap.
    function automatic int pend_cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: signals between the register file and the issue/writeback
// stages.
//   read  : iAddrA/iAddrB -> oRegA/oRegB, oBusyA/oBusyB
//   write : iWrite, iAddrC, iRegC
//   board : iIssue, iIssueAddr, iFlush -> oPendCnt
// The master modport is the pipeline side; the slave modport is the register file.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] iAddrA;
    logic [ADDR_W-1:0] iAddrB;
    logic [DATA_W-1:0] oRegA;
    logic [DATA_W-1:0] oRegB;
    logic              oBusyA;
    logic              oBusyB;
    logic              iWrite;
    logic [ADDR_W-1:0] iAddrC;
    logic [DATA_W-1:0] iRegC;
    logic              iIssue;
    logic [ADDR_W-1:0] iIssueAddr;
    logic              iFlush;
    logic [ADDR_W:0]   oPendCnt;

    modport master (
        output iAddrA, iAddrB, iWrite, iAddrC, iRegC, iIssue, iIssueAddr, iFlush,
        input  oRegA, oRegB, oBusyA, oBusyB, oPendCnt
    );

    modport slave (
        input  iAddrA, iAddrB, iWrite, iAddrC, iRegC, iIssue, iIssueAddr, iFlush,
        output oRegA, oRegB, oBusyA, oBusyB, oPendCnt
    );
endinterface

// File: rtl/reg_en.sv
// reg_en: W-bit register with load enable and asynchronous active-low clear.
//   clk   : rising-edge clock
//   rst_n : async clear, active low
//   en    : load d on the next rising edge
//   d / q : data in / data out
module reg_en #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with two combinational read ports, one synchronous
// write port, an optional write-to-read bypass and a per-register pending-write
// scoreboard.
//   iClk  : rising-edge clock
//   nRst  : async active-low reset; clears data, pending bits and the count
//   rf    : read ports A/B with busy flags, writeback port C, issue/flush
//           inputs, and the registered pending count oPendCnt
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic        iClk,
    input  logic        nRst,
    regfile_sb_if.slave rf
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = pend_cnt_w(ADDR_W);

    // Entry 0 drops out of the write and issue decodes when it is hardwired.
    // Its data and pending bit then stay 0 without any special case later on.
    localparam logic [DEPTH-1:0] LIVE_MASK =
        ZERO_REG ? ~DEPTH'(1) : {DEPTH{1'b1}};

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0]             wr_dec;
    logic [DEPTH-1:0]             iss_dec;
    logic [DEPTH-1:0]             pend;
    logic [DEPTH-1:0]             pend_nxt;
    logic [CNT_W-1:0]             cnt;
    logic [CNT_W-1:0]             cnt_nxt;
    logic                         cnt_inc;
    logic                         cnt_dec;

    assign wr_dec  = rf.iWrite ? ((DEPTH'(1) << rf.iAddrC) & LIVE_MASK) : '0;
    assign iss_dec = rf.iIssue ? ((DEPTH'(1) << rf.iIssueAddr) & LIVE_MASK) : '0;

    // Data storage. Writes land whatever the scoreboard state is.
    for (genvar k = 0; k < DEPTH; k++) begin : g_reg
        if (ZERO_REG && k == 0) begin : g_zero
            assign regs[k] = '0;
        end else begin : g_live
            reg_en #(.W(DATA_W)) u_reg (
                .clk   (iClk),
                .rst_n (nRst),
                .en    (wr_dec[k]),
                .d     (rf.iRegC),
                .q     (regs[k])
            );
        end
    end

    // Flush wins over everything. An issue then beats a same-cycle writeback,
    // because the newer producer owns the register.
    always_comb begin
        pend_nxt = '0;
        cnt_inc  = 1'b0;
        cnt_dec  = 1'b0;
        cnt_nxt  = '0;
        if (!rf.iFlush) begin
            pend_nxt = (pend & ~wr_dec) | iss_dec;
            // At most one bit sets and one bit clears per cycle, so the
            // count moves by at most one in each direction.
            cnt_inc  = |(iss_dec & ~pend);
            cnt_dec  = |(wr_dec & pend & ~iss_dec);
            cnt_nxt  = cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
        end
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            pend <= '0;
            cnt  <= '0;
        end else begin
            pend <= pend_nxt;
            cnt  <= cnt_nxt;
        end
    end

    // Read ports. A hardwired entry 0 never appears in wr_dec, so it cannot
    // be bypassed and always reads 0.
    always_comb begin
        rf.oRegA  = regs[rf.iAddrA];
        rf.oRegB  = regs[rf.iAddrB];
        rf.oBusyA = pend[rf.iAddrA];
        rf.oBusyB = pend[rf.iAddrB];
        if (BYPASS) begin
            if (wr_dec[rf.iAddrA]) begin
                rf.oRegA = rf.iRegC;
                if (!iss_dec[rf.iAddrA]) rf.oBusyA = 1'b0;
            end
            if (wr_dec[rf.iAddrB]) begin
                rf.oRegB = rf.iRegC;
                if (!iss_dec[rf.iAddrB]) rf.oBusyB = 1'b0;
            end
        end
    end

    assign rf.oPendCnt = cnt;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) if0 ();
    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) if1 ();

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
        .iClk (clk),
        .nRst (rst_n),
        .rf   (if0)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_nb (
        .iClk (clk),
        .nRst (rst_n),
        .rf   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [4:0]  c;
        logic [31:0] d;
        logic        iss;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        ba;
        logic        bb;
        logic [5:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic wr, input int c, input logic [31:0] d,
                                input logic iss, input int ia, input logic fl,
                                input int a, input int b,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input logic ba, input logic bb, input int cnt);
        vec_t v;
        v.wr = wr; v.c = 5'(c); v.d = d; v.iss = iss; v.ia = 5'(ia); v.fl = fl;
        v.a = 5'(a); v.b = 5'(b); v.ea = ea; v.eb = eb; v.ba = ba; v.bb = bb;
        v.cnt = 6'(cnt);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        if0.iWrite = 1'b0; if0.iAddrC = '0; if0.iRegC = '0;
        if0.iIssue = 1'b0; if0.iIssueAddr = '0; if0.iFlush = 1'b0;
    endtask

    task automatic idle1();
        if1.iWrite = 1'b0; if1.iAddrC = '0; if1.iRegC = '0;
        if1.iIssue = 1'b0; if1.iIssueAddr = '0; if1.iFlush = 1'b0;
        if1.iAddrA = '0; if1.iAddrB = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle0();
        idle1();
        if0.iAddrA = 5'd5;
        if0.iAddrB = 5'd0;

        //       wr c  d             iss ia fl  a  b   ea            eb            ba bb cnt
        vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, 32'hDEADBEEF, 32'h0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 5, 0, 32'hDEADBEEF, 32'h0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h1234,     0, 0, 0, 0, 5, 32'h0, 32'hDEADBEEF, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 0, 5, 32'h0, 32'hDEADBEEF, 0, 0, 0));
        vecs.push_back(mk(1, 7, 32'hA5A5A5A5, 0, 0, 0, 7, 7, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 3, 0, 3, 4, 32'h0, 32'h0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 4, 0, 3, 4, 32'h0, 32'h0, 1, 0, 1));
        vecs.push_back(mk(1, 3, 32'h33,       0, 0, 0, 3, 4, 32'h33, 32'h0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 3, 4, 32'h33, 32'h0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 9, 0, 9, 9, 32'h0, 32'h0, 0, 0, 1));
        vecs.push_back(mk(1, 9, 32'h99,       1, 9, 0, 9, 4, 32'h99, 32'h0, 1, 1, 2));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 9, 4, 32'h99, 32'h0, 1, 1, 2));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 0, 1, 6, 32'h0, 32'h0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 32'h0,        1, 2, 0, 1, 6, 32'h0, 32'h0, 1, 0, 3));
        vecs.push_back(mk(0, 0, 32'h0,        1, 3, 0, 1, 6, 32'h0, 32'h0, 1, 0, 4));
        vecs.push_back(mk(0, 0, 32'h0,        1, 5, 0, 1, 6, 32'h0, 32'h0, 1, 0, 5));
        vecs.push_back(mk(0, 0, 32'h0,        1, 6, 0, 1, 6, 32'h0, 32'h0, 1, 0, 6));
        vecs.push_back(mk(0, 0, 32'h0,        1, 8, 1, 6, 8, 32'h0, 32'h0, 1, 0, 7));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 6, 8, 32'h0, 32'h0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 4, 9, 32'h0, 32'h99, 0, 0, 0));
        vecs.push_back(mk(1, 10, 32'h1010,    0, 0, 1, 10, 4, 32'h1010, 32'h0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 10, 4, 32'h1010, 32'h0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 11, 0, 11, 12, 32'h0, 32'h0, 0, 0, 0));
        vecs.push_back(mk(1, 11, 32'hB,       1, 12, 0, 11, 12, 32'hB, 32'h0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 11, 12, 32'hB, 32'h0, 0, 1, 1));
        vecs.push_back(mk(1, 20, 32'h20,      0, 0, 0, 20, 12, 32'h20, 32'h0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 20, 12, 32'h20, 32'h0, 0, 1, 1));

        // Reset state.
        #12;
        check("rst_regA", if0.oRegA, 32'h0);
        check("rst_regB", if0.oRegB, 32'h0);
        check("rst_busyA", 32'(if0.oBusyA), 32'h0);
        check("rst_cnt", 32'(if0.oPendCnt), 32'h0);
        rst_n = 1'b1;
        step();

        // Table: drive, check combinational outputs and pre-edge count, then clock.
        for (int i = 0; i < vecs.size(); i++) begin
            if0.iWrite = vecs[i].wr; if0.iAddrC = vecs[i].c; if0.iRegC = vecs[i].d;
            if0.iIssue = vecs[i].iss; if0.iIssueAddr = vecs[i].ia; if0.iFlush = vecs[i].fl;
            if0.iAddrA = vecs[i].a; if0.iAddrB = vecs[i].b;
            #1;
            check($sformatf("v%0d_regA", i), if0.oRegA, vecs[i].ea);
            check($sformatf("v%0d_regB", i), if0.oRegB, vecs[i].eb);
            check($sformatf("v%0d_busyA", i), 32'(if0.oBusyA), 32'(vecs[i].ba));
            check($sformatf("v%0d_busyB", i), 32'(if0.oBusyB), 32'(vecs[i].bb));
            check($sformatf("v%0d_cnt", i), 32'(if0.oPendCnt), 32'(vecs[i].cnt));
            step();
        end
        idle0();

        // No bypass: write data appears only after the edge; busy is not cleared early.
        if1.iWrite = 1'b1; if1.iAddrC = 5'd7; if1.iRegC = 32'hA5A5A5A5; if1.iAddrA = 5'd7;
        #1;
        check("nb_regA_same", if1.oRegA, 32'h0);
        step();
        if1.iWrite = 1'b0;
        #1;
        check("nb_regA_next", if1.oRegA, 32'hA5A5A5A5);
        if1.iIssue = 1'b1; if1.iIssueAddr = 5'd7;
        step();
        if1.iIssue = 1'b0;
        if1.iWrite = 1'b1; if1.iAddrC = 5'd7; if1.iRegC = 32'h1;
        #1;
        check("nb_busy_same", 32'(if1.oBusyA), 32'h1);
        check("nb_cnt_pend", 32'(if1.oPendCnt), 32'h1);
        step();
        idle1();
        #1;
        check("nb_busy_next", 32'(if1.oBusyA), 32'h0);
        check("nb_cnt_clr", 32'(if1.oPendCnt), 32'h0);

        // Fill every non-zero entry, then try to issue r0.
        if0.iFlush = 1'b1;
        step();
        if0.iFlush = 1'b0;
        for (int k = 1; k < 32; k++) begin
            if0.iIssue = 1'b1; if0.iIssueAddr = 5'(k);
            step();
        end
        if0.iAddrA = 5'd31; if0.iAddrB = 5'd1;
        #1;
        check("full_cnt", 32'(if0.oPendCnt), 32'd31);
        check("full_busyA", 32'(if0.oBusyA), 32'h1);
        check("full_busyB", 32'(if0.oBusyB), 32'h1);
        if0.iIssueAddr = 5'd0; if0.iAddrA = 5'd0;
        step();
        if0.iIssue = 1'b0;
        #1;
        check("r0_cnt", 32'(if0.oPendCnt), 32'd31);
        check("r0_busy", 32'(if0.oBusyA), 32'h0);

        // Asynchronous reset mid-operation, with a write pending at the time.
        if0.iAddrA = 5'd20; if0.iAddrB = 5'd7;
        if0.iWrite = 1'b1; if0.iAddrC = 5'd5; if0.iRegC = 32'h5555;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_cnt", 32'(if0.oPendCnt), 32'h0);
        check("arst_regA", if0.oRegA, 32'h0);
        check("arst_regB", if0.oRegB, 32'h0);
        check("arst_busyB", 32'(if0.oBusyB), 32'h0);
        idle0();
        step();
        rst_n = 1'b1;
        if0.iAddrA = 5'd5;
        step();
        check("arst_wr_lost", if0.oRegA, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
